// File: rtl/tx_segment_reader.sv
// Streams one segment of payload bytes from frame-buffer BRAM through a show-ahead
// prefetch FIFO to byte_data, rotating through frame buffers as whole frames complete.
module tx_segment_reader #(
  parameter int ADDR_WIDTH         = 24,
  parameter int SEGMENT_NUMBER_MAX = 1079,
  parameter int SEGMENT_BYTES      = 1440,
  parameter int NUM_BUFFERS        = 2,
  parameter int BRAM_LATENCY       = 2,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                  clk125MHz,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           segment_num,
  input  logic [7:0]            txid,
  input  logic [7:0]            redundancy,
  input  logic                  data_user,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [7:0]            bram_dout,
  output logic [ADDR_WIDTH-1:0] startaddr,
  output logic [7:0]            vramdata,
  output logic [1:0]            buf_sel,
  output logic                  busy,
  output logic                  seg_done,
  output logic                  frame_done,
  output logic                  err_underrun,
  output logic                  err_segnum
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  localparam int CW = $clog2(SEGMENT_BYTES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0] BUF_STRIDE = ADDR_WIDTH'((SEGMENT_NUMBER_MAX + 1) * SEGMENT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] SEG_BYTES_A = ADDR_WIDTH'(SEGMENT_BYTES);
  localparam logic [CW-1:0]         SEG_BYTES_C = CW'(SEGMENT_BYTES);
  localparam logic [CW-1:0]         LAST_BYTE_C = CW'(SEGMENT_BYTES - 1);
  localparam logic [15:0]           SEG_MAX_C   = 16'(SEGMENT_NUMBER_MAX);
  localparam logic [OW:0]           DEPTH_C     = (OW + 1)'(FIFO_DEPTH);
  localparam logic [1:0]            LAST_BUF_C  = 2'(NUM_BUFFERS - 1);

  logic [1:0]              state_q, state_d;
  logic [15:0]             segNum_q, segNum_d;
  logic [7:0]              txid_q, txid_d;
  logic [7:0]              red_q, red_d;
  logic [ADDR_WIDTH-1:0]   startaddr_q, startaddr_d;
  logic [CW-1:0]           issued_q, issued_d;
  logic [CW-1:0]           popped_q, popped_d;
  logic [1:0]              bufSel_q, bufSel_d;
  logic [PW-1:0]           wrPtr_q, wrPtr_d;
  logic [PW-1:0]           rdPtr_q, rdPtr_d;
  logic [OW-1:0]           count_q, count_d;
  logic [OW-1:0]           inflight_q, inflight_d;
  logic [BRAM_LATENCY-1:0] pipe_q, pipe_d;
  logic [7:0]              lastByte_q, lastByte_d;
  logic                    segDone_q, segDone_d;
  logic                    frameDone_q, frameDone_d;
  logic                    errUnder_q, errUnder_d;
  logic                    errSeg_q, errSeg_d;
  logic [7:0]              mem [FIFO_DEPTH];

  logic          active, issue, push, pop, lastPop;
  logic [OW:0]   occTotal;
  logic [7:0]    lastTx;

  assign active   = (state_q == S_FILL) || (state_q == S_STREAM);
  assign occTotal = {1'b0, count_q} + {1'b0, inflight_q};
  // Reads already in flight reserve FIFO slots so a push can never overflow.
  assign issue    = active && (issued_q < SEG_BYTES_C) && (occTotal < DEPTH_C);
  assign push     = pipe_q[BRAM_LATENCY-1];
  assign pop      = busy && data_user && (count_q != '0);
  assign lastPop  = pop && (popped_q == LAST_BYTE_C);
  assign lastTx   = (red_q == 8'd0) ? 8'd0 : red_q - 8'd1;

  always_comb begin
    state_d     = state_q;
    segNum_d    = segNum_q;
    txid_d      = txid_q;
    red_d       = red_q;
    startaddr_d = startaddr_q;
    issued_d    = issued_q + CW'(issue);
    popped_d    = popped_q + CW'(pop);
    bufSel_d    = bufSel_q;
    wrPtr_d     = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d     = pop ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d     = count_q + OW'(push) - OW'(pop);
    inflight_d  = inflight_q + OW'(issue) - OW'(push);
    lastByte_d  = pop ? mem[rdPtr_q] : lastByte_q;
    segDone_d   = 1'b0;
    frameDone_d = 1'b0;
    errUnder_d  = errUnder_q | (busy && data_user && (count_q == '0));
    errSeg_d    = 1'b0;
    pipe_d[0]   = issue;
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (segment_num > SEG_MAX_C) begin
            errSeg_d = 1'b1;
          end else begin
            segNum_d = segment_num;
            txid_d   = txid;
            red_d    = redundancy;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        startaddr_d = ADDR_WIDTH'(bufSel_q) * BUF_STRIDE + ADDR_WIDTH'(segNum_q) * SEG_BYTES_A;
        issued_d    = '0;
        popped_d    = '0;
        state_d     = S_FILL;
      end
      S_FILL: begin
        if (count_q != '0) state_d = S_STREAM;
      end
      default: ;
    endcase

    if (lastPop) begin
      state_d   = S_IDLE;
      segDone_d = 1'b1;
      if ((segNum_q == SEG_MAX_C) && (txid_q == lastTx)) begin
        frameDone_d = 1'b1;
        bufSel_d    = (bufSel_q == LAST_BUF_C) ? 2'd0 : bufSel_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      segNum_q    <= '0;
      txid_q      <= '0;
      red_q       <= '0;
      startaddr_q <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      bufSel_q    <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      pipe_q      <= '0;
      lastByte_q  <= '0;
      segDone_q   <= 1'b0;
      frameDone_q <= 1'b0;
      errUnder_q  <= 1'b0;
      errSeg_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      segNum_q    <= segNum_d;
      txid_q      <= txid_d;
      red_q       <= red_d;
      startaddr_q <= startaddr_d;
      issued_q    <= issued_d;
      popped_q    <= popped_d;
      bufSel_q    <= bufSel_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      pipe_q      <= pipe_d;
      lastByte_q  <= lastByte_d;
      segDone_q   <= segDone_d;
      frameDone_q <= frameDone_d;
      errUnder_q  <= errUnder_d;
      errSeg_q    <= errSeg_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q says they are valid.
  always_ff @(posedge clk125MHz) begin
    if (push) mem[wrPtr_q] <= bram_dout;
  end

  assign bram_addr    = startaddr_q + ADDR_WIDTH'(issued_q);
  assign startaddr    = startaddr_q;
  assign vramdata     = (count_q != '0) ? mem[rdPtr_q] : lastByte_q;
  assign buf_sel      = bufSel_q;
  assign busy         = (state_q != S_IDLE);
  assign seg_done     = segDone_q;
  assign frame_done   = frameDone_q;
  assign err_underrun = errUnder_q;
  assign err_segnum   = errSeg_q;

endmodule

// File: tb/tb_tx_segment_reader.sv
// Directed bench for tx_segment_reader on the small test geometry (6 segments of 16 bytes,
// 2 buffers); the BRAM model returns the low address byte two cycles after the address.
module tb_tx_segment_reader;

  logic        clk125MHz = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] segment_num;
  logic [7:0]  txid;
  logic [7:0]  redundancy;
  logic        data_user;
  logic [23:0] bram_addr;
  logic [7:0]  bram_dout;
  logic [23:0] startaddr;
  logic [7:0]  vramdata;
  logic [1:0]  buf_sel;
  logic        busy;
  logic        seg_done;
  logic        frame_done;
  logic        err_underrun;
  logic        err_segnum;

  int   checks = 0;
  int   errors = 0;
  logic expUnderrun = 1'b0;
  logic [7:0] bramStage1;

  tx_segment_reader #(
    .ADDR_WIDTH(24), .SEGMENT_NUMBER_MAX(5), .SEGMENT_BYTES(16),
    .NUM_BUFFERS(2), .BRAM_LATENCY(2), .FIFO_DEPTH(8)
  ) dut (
    .clk125MHz(clk125MHz), .rst_n(rst_n), .start(start), .segment_num(segment_num),
    .txid(txid), .redundancy(redundancy), .data_user(data_user), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .startaddr(startaddr), .vramdata(vramdata), .buf_sel(buf_sel),
    .busy(busy), .seg_done(seg_done), .frame_done(frame_done),
    .err_underrun(err_underrun), .err_segnum(err_segnum)
  );

  always #4 clk125MHz = ~clk125MHz;

  always @(posedge clk125MHz) begin
    bramStage1 <= bram_addr[7:0];
    bram_dout  <= bramStage1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle; returns #1 after the edge that samples it.
  task automatic applyStimulus(input logic [15:0] seg, input logic [7:0] tx, input logic [7:0] red);
    @(posedge clk125MHz); #1;
    segment_num = seg;
    txid        = tx;
    redundancy  = red;
    start       = 1'b1;
    @(posedge clk125MHz); #1;
    start       = 1'b0;
  endtask

  // Pops all 16 bytes with 'gap' idle cycles between pops, then checks the completion pulses.
  task automatic consumeSegment(input logic [23:0] base, input int gap, input logic expFrame);
    logic [23:0] expAddr;
    repeat (5) @(posedge clk125MHz);
    #1;
    checkOutput("startaddr", startaddr, base);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) repeat (gap) begin @(posedge clk125MHz); #1; end
      data_user = 1'b1;
      expAddr = base + 24'(k);
      @(negedge clk125MHz);
      checkOutput("vramdata", vramdata, expAddr[7:0]);
      @(posedge clk125MHz); #1;
      data_user = 1'b0;
    end
    @(negedge clk125MHz);
    expAddr = base + 24'd16;
    checkOutput("seg_done", seg_done, 1'b1);
    checkOutput("busy_end", busy, 1'b0);
    checkOutput("frame_done", frame_done, expFrame);
    checkOutput("reads_issued", bram_addr, expAddr);
    checkOutput("err_underrun", err_underrun, expUnderrun);
    @(posedge clk125MHz); #1;
    @(negedge clk125MHz);
    checkOutput("seg_done_pulse", seg_done, 1'b0);
    checkOutput("frame_done_pulse", frame_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; segment_num = '0; txid = '0; redundancy = '0; data_user = 1'b0;
    repeat (3) @(posedge clk125MHz);
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_startaddr", startaddr, 24'd0);
    checkOutput("rst_bram_addr", bram_addr, 24'd0);
    checkOutput("rst_vramdata", vramdata, 8'd0);
    checkOutput("rst_buf_sel", buf_sel, 2'd0);
    rst_n = 1'b1;

    applyStimulus(16'd3, 8'd0, 8'd1);
    consumeSegment(24'd48, 0, 1'b0);

    // Two copies of every segment; only the last copy of segment 5 finishes the frame.
    for (int s = 0; s <= 5; s++) begin
      for (int t = 0; t <= 1; t++) begin
        applyStimulus(16'(s), 8'(t), 8'd2);
        consumeSegment(24'(s * 16), 0, (s == 5) && (t == 1));
      end
    end
    checkOutput("buf_sel_adv", buf_sel, 2'd1);

    applyStimulus(16'd0, 8'd0, 8'd1);
    consumeSegment(24'd96, 3, 1'b0);

    applyStimulus(16'd2, 8'd0, 8'd1);
    @(posedge clk125MHz); #1;
    data_user = 1'b1;
    @(negedge clk125MHz);
    checkOutput("underrun_hold", vramdata, 8'h6F);
    @(posedge clk125MHz); #1;
    data_user = 1'b0;
    @(negedge clk125MHz);
    checkOutput("underrun_flag", err_underrun, 1'b1);
    checkOutput("underrun_vram", vramdata, 8'h6F);
    expUnderrun = 1'b1;
    consumeSegment(24'd128, 0, 1'b0);

    applyStimulus(16'd6, 8'd0, 8'd1);
    @(negedge clk125MHz);
    checkOutput("err_segnum", err_segnum, 1'b1);
    checkOutput("segnum_busy", busy, 1'b0);
    @(posedge clk125MHz); #1;
    @(negedge clk125MHz);
    checkOutput("err_segnum_pulse", err_segnum, 1'b0);
    checkOutput("segnum_idle", busy, 1'b0);

    applyStimulus(16'd1, 8'd0, 8'd1);
    applyStimulus(16'd4, 8'd0, 8'd1);
    @(negedge clk125MHz);
    checkOutput("busy_start_ign", startaddr, 24'd112);
    consumeSegment(24'd112, 0, 1'b0);

    applyStimulus(16'd3, 8'd0, 8'd1);
    repeat (5) @(posedge clk125MHz);
    #1;
    data_user = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk125MHz);
      checkOutput("pre_reset_vram", vramdata, 8'(8'h90 + k));
      @(posedge clk125MHz); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_startaddr", startaddr, 24'd0);
    checkOutput("arst_bram_addr", bram_addr, 24'd0);
    checkOutput("arst_vramdata", vramdata, 8'd0);
    checkOutput("arst_buf_sel", buf_sel, 2'd0);
    checkOutput("arst_underrun", err_underrun, 1'b0);
    checkOutput("arst_seg_done", seg_done, 1'b0);
    data_user = 1'b0;
    @(posedge clk125MHz); #1;
    rst_n = 1'b1;
    expUnderrun = 1'b0;
    applyStimulus(16'd1, 8'd0, 8'd1);
    consumeSegment(24'd16, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_segment_reader.md
Name: tx_segment_reader

Overview:
- Parametrised successor to the TX memory controller. Feeds payload bytes from frame-buffer BRAM to byte_data for one Ethernet segment per start.
- Adds N-buffer ping-pong frame selection, configurable BRAM read latency, a show-ahead prefetch FIFO, redundancy-aware frame completion and error flags.
- Sits between send_control/byte_data and the frame-buffer BRAM read port.

Parameters:
- ADDR_WIDTH, 24, BRAM byte-address width.
- SEGMENT_NUMBER_MAX, 1079, highest valid segment index per frame.
- SEGMENT_BYTES, 1440, payload bytes per segment.
- NUM_BUFFERS, 2, number of frame buffers, used round-robin; 1..4.
- BRAM_LATENCY, 2, cycles from bram_addr to valid bram_dout; 1..4.
- FIFO_DEPTH, 8, prefetch FIFO entries, power of 2, at least BRAM_LATENCY+2.

Ports:
- clk125MHz  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse from send_control: begin a segment.
- segment_num  in  16  segment index, sampled on start.
- txid  in  8  copy index of this transmission, sampled on start.
- redundancy  in  8  copies per segment, sampled on start; 0 is treated as 1.
- data_user  in  1  byte_data consumes one payload byte this cycle.
- bram_addr  out  ADDR_WIDTH  BRAM read address.
- bram_dout  in  8  BRAM read data.
- startaddr  out  ADDR_WIDTH  first byte address of the current segment.
- vramdata  out  8  payload byte (FIFO head, show-ahead).
- buf_sel  out  2  frame buffer currently being read.
- busy  out  1  segment in progress.
- seg_done  out  1  one-cycle pulse: last byte of segment consumed.
- frame_done  out  1  one-cycle pulse: last copy of last segment consumed.
- err_underrun  out  1  sticky: data_user while FIFO empty.
- err_segnum  out  1  one-cycle pulse: start with segment_num > SEGMENT_NUMBER_MAX.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; issue/pop counters 0; buf_sel 0. Reset is asynchronous and may arrive mid-segment: abort immediately, discard in-flight BRAM reads.
- Derived constant: BUF_STRIDE = (SEGMENT_NUMBER_MAX+1)*SEGMENT_BYTES. Base address of buffer b is b*BUF_STRIDE. All address arithmetic is modulo 2^ADDR_WIDTH.
- FSM states: IDLE, LOAD, FILL, STREAM.
- IDLE:
  - On start with segment_num <= MAX: latch inputs, busy=1, go to LOAD.
  - On start with segment_num > MAX: pulse err_segnum, stay IDLE, busy stays 0.
- LOAD (1 cycle): startaddr <= buf_sel*BUF_STRIDE + segment_num*SEGMENT_BYTES; issue counter cleared; go to FILL.
- FILL/STREAM read issue:
  - Each cycle, issue a read when issued < SEGMENT_BYTES and (FIFO occupancy + reads in flight) < FIFO_DEPTH.
  - bram_addr = startaddr + issued. An issue strobe travels down a BRAM_LATENCY-stage valid pipe; bram_dout is pushed into the FIFO when the strobe emerges.
  - FILL goes to STREAM when occupancy >= 1. byte_data may not assert data_user before then; if it does, that is an underrun.
- Pop:
  - data_user with FIFO non-empty pops one byte and increments the pop counter.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - data_user with FIFO empty sets err_underrun, pops nothing, and leaves vramdata at its last value.
  - data_user in IDLE is ignored; it does not flag an error.
- Completion: the pop of byte SEGMENT_BYTES-1 pulses seg_done the next cycle, sets busy=0 and returns to IDLE. Excess reads are never issued.
- Frame completion: if the latched segment_num == SEGMENT_NUMBER_MAX and txid == max(redundancy,1)-1, frame_done pulses together with seg_done, and buf_sel advances modulo NUM_BUFFERS.
- start while busy: ignored, no state change.
- start on the same cycle as seg_done: accepted, because IDLE is entered at that edge.
- err_underrun is cleared only by reset.

Test Plan (SEGMENT_NUMBER_MAX=5, SEGMENT_BYTES=16, NUM_BUFFERS=2, BRAM_LATENCY=2, FIFO_DEPTH=8; BRAM model returns addr[7:0]):
- Reset, then start with segment_num=3, txid=0, redundancy=1, data_user held high after FILL -> startaddr=48; vramdata sequence 0x30..0x3F with no gaps; seg_done pulses once; busy falls; err_underrun stays 0.
- Segments 0..5 with redundancy=2, txid 0 then 1 for each -> frame_done pulses once, after segment 5 copy 1; buf_sel goes 0->1. Next segment 0 has startaddr=96 (bram_addr 96..111).
- data_user toggling 1-cycle-on/3-off -> FIFO occupancy never exceeds 8; all 16 bytes arrive in order; total reads issued exactly 16.
- data_user asserted in FILL before the first push -> err_underrun=1 (sticky); vramdata unchanged.
- start with segment_num=6 -> err_segnum pulse; busy stays 0. A second start while busy -> ignored, startaddr unchanged.
- rst_n low at pop 7 -> all outputs 0 asynchronously. After release, start segment 1 -> clean sequence 0x10..0x1F.
